imem_boot_loader: RTL

Streams a program image, received as a byte stream, into the single-cycle RISC-V core's instruction memory while holding the core in reset. It sits directly upstream of `riscsinglecycle` and feeds its instruction memory write port. It releases the core's reset only after a complete image with a valid checksum has been written. A bad header or a bad checksum parks the block in an error state, and the core stays in reset.

---
 rtl/imem_boot_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Loads a counted, checksummed byte-stream image into instruction memory, core held in reset until done.
// Writes are issued one cycle after the 4th byte of each word. rx_ready is 1 in HDR0..CSUM and 0 in RUN/ERROR.
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  restart,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERROR
   } state_t;

   localparam logic [32:0] MEM_WORDS = 33'd1 << ADDR_WIDTH;

   state_t                state_q;
   logic [15:0]           count_q;
   logic [15:0]           word_idx_q;
   logic [1:0]            byte_idx_q;
   logic [7:0]            sum_q;
   logic [23:0]           buf_q;
   logic                  rx_ready_q;
   logic                  imem_we_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q;
   logic [31:0]           imem_wdata_q;
   logic                  cpu_reset_q;
   logic                  load_done_q;
   logic                  load_error_q;

   logic                  xfer;
   logic [7:0]            sum_d;
   logic [31:0]           word_d;
   logic [32:0]           end_d;
   logic                  hdr_bad_d;
   logic                  last_word_d;

   assign xfer        = rx_valid && rx_ready_q;
   assign sum_d       = sum_q + rx_data;
   assign word_d      = {rx_data, buf_q};
   // End of image (exclusive), evaluated while count_hi is on rx_data.
   assign end_d       = 33'(BASE_ADDR) + 33'({rx_data, count_q[7:0]});
   assign hdr_bad_d   = ({rx_data, count_q[7:0]} == 16'd0) || (end_d > MEM_WORDS);
   assign last_word_d = (word_idx_q == (count_q - 16'd1));

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state_q      <= S_HDR0;
         count_q      <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         sum_q        <= '0;
         buf_q        <= '0;
         rx_ready_q   <= 1'b1;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_reset_q  <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         imem_we_q <= 1'b0;
         if (xfer) begin
            case (state_q)
               S_HDR0: begin
                  count_q[7:0] <= rx_data;
                  state_q      <= S_HDR1;
               end
               S_HDR1: begin
                  count_q[15:8] <= rx_data;
                  if (hdr_bad_d) begin
                     state_q      <= S_ERROR;
                     rx_ready_q   <= 1'b0;
                     load_error_q <= 1'b1;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
               S_DATA: begin
                  sum_q      <= sum_d;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  case (byte_idx_q)
                     2'd0: buf_q[7:0]   <= rx_data;
                     2'd1: buf_q[15:8]  <= rx_data;
                     2'd2: buf_q[23:16] <= rx_data;
                     default: begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= ADDR_WIDTH'(BASE_ADDR + 32'(word_idx_q));
                        imem_wdata_q <= word_d;
                        word_idx_q   <= word_idx_q + 16'd1;
                        if (last_word_d) begin
                           state_q <= S_CSUM;
                        end
                     end
                  endcase
               end
               S_CSUM: begin
                  rx_ready_q <= 1'b0;
                  if (sum_d == 8'd0) begin
                     state_q     <= S_RUN;
                     cpu_reset_q <= 1'b0;
                     load_done_q <= 1'b1;
                  end else begin
                     state_q      <= S_ERROR;
                     load_error_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;

endmodule
